heap_node_swap_pipe: RTL

// Pipelined, parametrised k-ary heap-node compare/swap unit for the BRAM priority-queue tree.
// - Takes one parent and NUM_CHILDREN children, and selects the best child (max or min per MAX_HEAP).
// - Swaps the parent with that child when the child strictly beats the parent.
// - Sits between the BRAM read port and the write-back/sift-down controller.
// - Streams one node per cycle through a valid/ready pipeline.

---
 rtl/heap_node_swap_pipe.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/heap_node_swap_pipe.sv
// rtl/heap_node_swap_pipe.sv - pipelined k-ary heap node compare/swap unit
// Optional node tag sideband is enabled by defining HEAP_NODE_TAG_EN.
module heap_node_swap_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHILDREN = 2,
  parameter int MAX_HEAP     = 1,
  parameter int TAG_WIDTH    = 16,
  localparam int IDX_W = (NUM_CHILDREN > 2) ? $clog2(NUM_CHILDREN) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_WIDTH-1:0]              in_parent,
  input  logic [NUM_CHILDREN*DATA_WIDTH-1:0] in_children,
`ifdef HEAP_NODE_TAG_EN
  input  logic [TAG_WIDTH-1:0]               in_tag,
  output logic [TAG_WIDTH-1:0]               out_tag,
`endif
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_parent,
  output logic [NUM_CHILDREN*DATA_WIDTH-1:0] out_children,
  output logic                               out_swap,
  output logic [IDX_W-1:0]                   out_swap_idx
);

  localparam int LVLS = $clog2(NUM_CHILDREN);
  localparam int CW   = NUM_CHILDREN * DATA_WIDTH;

  typedef logic [DATA_WIDTH-1:0] key_t;
  typedef logic [IDX_W-1:0]      idx_t;

  key_t lvl_key [0:LVLS][NUM_CHILDREN];
  idx_t lvl_idx [0:LVLS][NUM_CHILDREN];
  key_t key_d   [1:LVLS][NUM_CHILDREN];
  idx_t idx_d   [1:LVLS][NUM_CHILDREN];
  key_t key_q   [1:LVLS][NUM_CHILDREN];
  idx_t idx_q   [1:LVLS][NUM_CHILDREN];
  key_t         par_q [1:LVLS];
  logic [CW-1:0] ch_q [1:LVLS];
  logic [LVLS:1] v_q;

  logic          out_valid_q;
  key_t          out_parent_q, out_parent_d;
  logic [CW-1:0] out_children_q, out_children_d;
  logic          out_swap_q, out_swap_d;
  idx_t          out_idx_q;
  logic          adv;

`ifdef HEAP_NODE_TAG_EN
  logic [TAG_WIDTH-1:0] tag_q [1:LVLS];
  logic [TAG_WIDTH-1:0] out_tag_q;
`endif

  // Strict compare: r replaces l only when it is strictly better, so ties keep l.
  function automatic logic beats(input key_t l, input key_t r);
    return (MAX_HEAP != 0) ? (r > l) : (r < l);
  endfunction

  function automatic int level_cnt(input int s);
    return (NUM_CHILDREN + (1 << s) - 1) >> s;
  endfunction

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv && !rst;

  always_comb begin
    for (int j = 0; j < NUM_CHILDREN; j++) begin
      lvl_key[0][j] = in_children[j*DATA_WIDTH +: DATA_WIDTH];
      lvl_idx[0][j] = IDX_W'(j);
    end
    for (int s = 1; s <= LVLS; s++) begin
      for (int j = 0; j < NUM_CHILDREN; j++) begin
        lvl_key[s][j] = key_q[s][j];
        lvl_idx[s][j] = idx_q[s][j];
      end
    end
  end

  always_comb begin
    for (int s = 1; s <= LVLS; s++) begin
      for (int j = 0; j < NUM_CHILDREN; j++) begin
        key_d[s][j] = '0;
        idx_d[s][j] = '0;
      end
      for (int j = 0; j < (NUM_CHILDREN + 1) / 2; j++) begin
        int li;
        int ri;
        li = 2 * j;
        ri = (2 * j + 1 < NUM_CHILDREN) ? 2 * j + 1 : 2 * j;
        if (2 * j + 1 < level_cnt(s - 1) && beats(lvl_key[s-1][li], lvl_key[s-1][ri])) begin
          key_d[s][j] = lvl_key[s-1][ri];
          idx_d[s][j] = lvl_idx[s-1][ri];
        end else if (2 * j < level_cnt(s - 1)) begin
          key_d[s][j] = lvl_key[s-1][li];
          idx_d[s][j] = lvl_idx[s-1][li];
        end
      end
    end
  end

  // Final stage: best child against parent, then rebuild the node.
  always_comb begin
    out_swap_d     = beats(par_q[LVLS], key_q[LVLS][0]);
    out_parent_d   = par_q[LVLS];
    out_children_d = ch_q[LVLS];
    if (out_swap_d) begin
      out_parent_d = key_q[LVLS][0];
      out_children_d[idx_q[LVLS][0]*DATA_WIDTH +: DATA_WIDTH] = par_q[LVLS];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q            <= '0;
      out_valid_q    <= 1'b0;
      out_parent_q   <= '0;
      out_children_q <= '0;
      out_swap_q     <= 1'b0;
      out_idx_q      <= '0;
      for (int s = 1; s <= LVLS; s++) begin
        par_q[s] <= '0;
        ch_q[s]  <= '0;
`ifdef HEAP_NODE_TAG_EN
        tag_q[s] <= '0;
`endif
        for (int j = 0; j < NUM_CHILDREN; j++) begin
          key_q[s][j] <= '0;
          idx_q[s][j] <= '0;
        end
      end
`ifdef HEAP_NODE_TAG_EN
      out_tag_q <= '0;
`endif
    end else if (adv) begin
      v_q[1]   <= in_valid;
      par_q[1] <= in_parent;
      ch_q[1]  <= in_children;
`ifdef HEAP_NODE_TAG_EN
      tag_q[1] <= in_tag;
`endif
      for (int s = 2; s <= LVLS; s++) begin
        v_q[s]   <= v_q[s-1];
        par_q[s] <= par_q[s-1];
        ch_q[s]  <= ch_q[s-1];
`ifdef HEAP_NODE_TAG_EN
        tag_q[s] <= tag_q[s-1];
`endif
      end
      for (int s = 1; s <= LVLS; s++) begin
        for (int j = 0; j < NUM_CHILDREN; j++) begin
          key_q[s][j] <= key_d[s][j];
          idx_q[s][j] <= idx_d[s][j];
        end
      end
      out_valid_q    <= v_q[LVLS];
      out_parent_q   <= out_parent_d;
      out_children_q <= out_children_d;
      out_swap_q     <= out_swap_d;
      out_idx_q      <= idx_q[LVLS][0];
`ifdef HEAP_NODE_TAG_EN
      out_tag_q      <= tag_q[LVLS];
`endif
    end
  end

  assign out_valid    = out_valid_q;
  assign out_parent   = out_parent_q;
  assign out_children = out_children_q;
  assign out_swap     = out_swap_q;
  assign out_swap_idx = out_idx_q;
`ifdef HEAP_NODE_TAG_EN
  assign out_tag      = out_tag_q;
`endif

endmodule
